// File: rtl/fpu_pkg.sv
// Shared FPU packing types: biases, exponent limits, format/class enums and the S1->S2 struct.
// FP_PACKER_DENORM_EN widens the stage struct to carry the subnormal shift and hidden bit.
package fpu_pkg;

  localparam int BIAS_D = 1023;
  localparam int BIAS_S = 127;
  localparam int EMAX_D = 2047;
  localparam int EMAX_S = 255;

`ifdef FP_PACKER_DENORM_EN
  localparam int FW = 53;
`else
  localparam int FW = 52;
`endif

  typedef enum logic {
    SINGLE = 1'b0,
    DOUBLE = 1'b1
  } fmt_e;

  typedef enum logic [2:0] {
    NORMAL,
    ZERO,
    INF,
    NAN,
    UNDERFLOW,
    OVERFLOW
  } cls_e;

  // Hidden bit is only kept when the subnormal shifter needs it.
  typedef struct packed {
    fmt_e        fmt;
    logic        s;
    cls_e        cls;
    logic [10:0] eb;
`ifdef FP_PACKER_DENORM_EN
    logic [5:0]  sh;
`endif
    logic [FW-1:0] f;
  } s1_t;

endpackage

// File: rtl/fp_denorm_shift.sv
// Subnormal significand shifter: f >> sh, fraction field only; amounts past the width give zero.
// Present only when FP_PACKER_DENORM_EN is defined.
`ifdef FP_PACKER_DENORM_EN
module fp_denorm_shift (
  input  logic [52:0] f_i,
  input  logic [5:0]  sh_i,
  output logic [51:0] f_o
);

  always_comb begin
    f_o = '0;
    if (sh_i < 6'd53) begin
      f_o = 52'(f_i >> sh_i);
    end
  end

endmodule
`endif

// File: rtl/fp_packer.sv
// Two-stage valid/ready packer from sign/unbiased exponent/significand to an IEEE-754 word.
// FP_PACKER_DENORM_EN: underflow produces subnormals; otherwise it flushes to signed zero.
module fp_packer
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        db,
  input  logic        s,
  input  logic [12:0] e,
  input  logic [52:0] f,
  input  logic        nan,
  input  logic        inf,
  input  logic        zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] fp
);

`ifdef FP_PACKER_DENORM_EN
  function automatic logic [5:0] sat_sh(input logic signed [13:0] v);
    if (v > 14'sd63) begin
      return 6'd63;
    end else if (v < 14'sd0) begin
      return 6'd0;
    end
    return v[5:0];
  endfunction
`endif

  logic               vld_p1_q;
  logic               vld_p2_q;
  s1_t                st_p1_q;
  s1_t                st_d;
  logic [63:0]        fp_p2_q;
  logic [63:0]        fp_d;
  logic               rdy_p1;
  logic               rdy_p2;
  logic signed [13:0] eb_c;
  logic signed [13:0] emax_c;

  assign rdy_p2    = !vld_p2_q || out_ready;
  assign rdy_p1    = !vld_p1_q || rdy_p2;
  assign in_ready  = rdy_p1;
  assign out_valid = vld_p2_q;
  assign fp        = fp_p2_q;

  // ---- S1: bias the exponent and classify ----
  always_comb begin
    eb_c   = $signed({e[12], e}) + (db ? 14'(BIAS_D) : 14'(BIAS_S));
    emax_c = db ? 14'(EMAX_D) : 14'(EMAX_S);
    st_d     = '0;
    st_d.fmt = db ? DOUBLE : SINGLE;
    st_d.s   = s;
    st_d.eb  = eb_c[10:0];
    st_d.f   = f[FW-1:0];
`ifdef FP_PACKER_DENORM_EN
    st_d.sh  = sat_sh(14'sd1 - eb_c);
`endif
    if (nan) begin
      st_d.cls = NAN;
    end else if (inf) begin
      st_d.cls = INF;
    end else if (zero || (f == 53'd0)) begin
      st_d.cls = ZERO;
    end else if (eb_c >= emax_c) begin
      st_d.cls = OVERFLOW;
    end else if (eb_c <= 14'sd0) begin
      st_d.cls = UNDERFLOW;
    end else begin
      st_d.cls = NORMAL;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && rdy_p1) begin
      st_p1_q <= st_d;
    end
  end

  // ---- S2: assemble the output word ----
`ifdef FP_PACKER_DENORM_EN
  logic [51:0] dn_f;

  fp_denorm_shift u_shift (
    .f_i  (st_p1_q.f),
    .sh_i (st_p1_q.sh),
    .f_o  (dn_f)
  );
`endif

  always_comb begin
    fp_d = '0;
    case (st_p1_q.cls)
      NAN: begin
        fp_d = (st_p1_q.fmt == DOUBLE) ? {st_p1_q.s, 11'h7FF, 1'b1, 51'd0}
                                       : {st_p1_q.s, 8'hFF, 1'b1, 22'd0, 32'd0};
      end
      INF, OVERFLOW: begin
        fp_d = (st_p1_q.fmt == DOUBLE) ? {st_p1_q.s, 11'h7FF, 52'd0}
                                       : {st_p1_q.s, 8'hFF, 23'd0, 32'd0};
      end
      ZERO: begin
        fp_d = {st_p1_q.s, 63'd0};
      end
      UNDERFLOW: begin
`ifdef FP_PACKER_DENORM_EN
        fp_d = (st_p1_q.fmt == DOUBLE) ? {st_p1_q.s, 11'd0, dn_f}
                                       : {st_p1_q.s, 8'd0, dn_f[51:29], 32'd0};
`else
        fp_d = {st_p1_q.s, 63'd0};
`endif
      end
      default: begin
        fp_d = (st_p1_q.fmt == DOUBLE) ? {st_p1_q.s, st_p1_q.eb, st_p1_q.f[51:0]}
                                       : {st_p1_q.s, st_p1_q.eb[7:0], st_p1_q.f[51:29], 32'd0};
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      fp_p2_q  <= '0;
    end else begin
      if (rdy_p1) begin
        vld_p1_q <= in_valid;
      end
      if (rdy_p2) begin
        vld_p2_q <= vld_p1_q;
        if (vld_p1_q) begin
          fp_p2_q <= fp_d;
        end
      end
    end
  end

endmodule

// File: doc/fp_packer.md
# fp_packer

Packing stage at the output end of the FPU datapath, and the inverse of the unpacker. Takes a sign, unbiased exponent and normalized 53-bit significand (hidden bit at [52]) plus special-value flags, and produces the IEEE-754 word. Doubles fill fp[63:0]; singles fill fp[63:32] with fp[31:0] = 0. Two-stage valid/ready pipeline; rounding happens upstream, so this block truncates.

## Interface
- BIAS_D, 1023: double exponent bias
- BIAS_S, 127: single exponent bias

- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input operand valid
- in_ready  out  1  block can accept this cycle
- db  in  1  1 = double, 0 = single
- s  in  1  sign
- e  in  13  unbiased exponent, two's complement
- f  in  53  significand; f[52] = hidden bit
- nan, inf, zero  in  1 each  special-value flags
- out_valid  out  1  fp valid
- out_ready  in  1  downstream accepts
- fp  out  64  packed result

## Operation
- Transfer occurs when valid && ready, at both ends.
- Stage 1 (S1) registers db, s, f and the flags. It computes `eb = e + (db ? BIAS_D : BIAS_S)` at 14-bit signed width, then classifies the result.
- Classification priority: nan > inf > (zero or f==0) > overflow (eb >= EMAX, where EMAX = 2047 for double and 255 for single) > underflow (eb <= 0) > normal.
- S1 also computes the denormal shift `sh = 1 - eb` and saturates it at 63.
- Stage 2 (S2) assembles the output word.
  - nan: exponent all ones; fraction MSB set, rest zero; sign = s.
  - inf / overflow: exponent all ones, fraction 0.
  - zero: exponent 0, fraction 0; sign kept.
  - normal: double gives {s, eb[10:0], f[51:0]}. Single gives {s, eb[7:0], f[51:29], 32'b0}. Single truncates f[28:0].
  - underflow: see Configuration.
- Reset values: out_valid=0, fp=0, S1 valid=0, in_ready=1.

## Timing
- Latency is 2 cycles from input acceptance to out_valid. Throughput is 1 per cycle when out_ready=1.
- Stage advance rule: `ready_k = !valid_k || ready_{k+1}`. in_ready is S1's ready and is combinational from out_ready.
- With out_ready=0, at most 2 operands are held. in_ready falls when both stages are full.
- fp and out_valid stay stable while out_valid && !out_ready.
- Order is always preserved. No operand is dropped or duplicated.
- Asserting rst at any time clears both valids on the same edge. In-flight operands are discarded.

## Configuration
- FP_PACKER_DENORM_EN defined: underflow produces a subnormal.
  - Exponent field = 0.
  - Fraction = (f >> sh) bits [51:0] for double, or [51:29] for single.
  - sh >= 53 gives fraction 0. Shifted-out bits are truncated.
  - S2 does the shift as a single barrel shift.
- Not defined: underflow flushes to a signed zero, and the shifter is not instantiated.

## Structure
- Shared package `fpu_pkg` holds:
  - the BIAS_D/BIAS_S and EMAX constants;
  - the format enum (SINGLE, DOUBLE);
  - the class enum (NORMAL, ZERO, INF, NAN, UNDERFLOW, OVERFLOW);
  - the S1→S2 stage struct.
- One sub-module, `fp_denorm_shift`: the 53-bit right shifter with saturating amount. It is compiled only under FP_PACKER_DENORM_EN.

## Test plan
- db=1, s=0, e=0, f=1<<52, out_ready=1 → 2 cycles later fp=0x3FF0000000000000.
- db=0, s=1, e=0, f=1<<52 → fp=0xBF80000000000000.
- db=1, e=1024 → fp=0x7FF0000000000000. db=1 with nan=1 and inf=1 → fp=0x7FF8000000000000 (nan priority).
- db=1, e=-1023, f=1<<52:
  - with FP_PACKER_DENORM_EN → fp=0x0008000000000000;
  - without it → fp=0x0000000000000000.
  - With s=1 and without the macro → fp=0x8000000000000000.
- Present 3 back-to-back operands (e = 0, 1, 2, double) with out_ready=0 for 4 cycles:
  - in_ready falls after 2 accepts;
  - fp holds 0x3FF0000000000000 stable;
  - after out_ready=1 the outputs are 0x3FF0…, 0x4000…, 0x4010… in order.
- Assert rst while both stages are full → out_valid=0, fp=0 and in_ready=1 after the edge. There is no spurious output after release.
